// File: rtl/stdp_update_scheduler.sv
// Per-timestep STDP update sequencer: one request per affected synapse, ascending index; first upd_valid two cycles after step_start.
// Requests hold until upd_ready; a missing upd_done is abandoned after TIMEOUT cycles; step_start while busy is dropped and flagged.
module stdp_update_scheduler #(
    parameter int N_SYN   = 16,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             learning_enable,
    input  logic             step_start,
    input  logic [N_SYN-1:0] pre_spike_vec,
    input  logic             post_spike,
    input  logic             clear_err,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [IDX_W-1:0] upd_idx,
    output logic             upd_pre,
    output logic             upd_post,
    input  logic             upd_done,
    output logic             busy,
    output logic             step_done,
    output logic [IDX_W:0]   upd_count,
    output logic             overrun,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [N_SYN-1:0] pending_q, pending_d;
    logic [N_SYN-1:0] pre_q, pre_d;
    logic             post_q, post_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_pre_q, upd_pre_d;
    logic             upd_post_q, upd_post_d;
    logic [IDX_W:0]   upd_count_q, upd_count_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             overrun_q, overrun_d;
    logic             timeout_err_q, timeout_err_d;
    logic             upd_valid_q, upd_valid_d;
    logic             busy_q, busy_d;
    logic             step_done_q, step_done_d;
    logic [IDX_W-1:0] first_idx;
    logic             timeout_set;

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        first_idx = '0;
        for (int i = N_SYN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        pre_d       = pre_q;
        post_d      = post_q;
        upd_idx_d   = upd_idx_q;
        upd_pre_d   = upd_pre_q;
        upd_post_d  = upd_post_q;
        upd_count_d = upd_count_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    upd_count_d = '0;
                    if (learning_enable) begin
                        pending_d = pre_spike_vec | {N_SYN{post_spike}};
                        pre_d     = pre_spike_vec;
                        post_d    = post_spike;
                        state_d   = S_SCAN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SCAN: begin
                if (pending_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    upd_idx_d  = first_idx;
                    upd_pre_d  = pre_q[first_idx];
                    upd_post_d = post_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (upd_ready) begin
                    pending_d[upd_idx_q] = 1'b0;
                    if (upd_count_q != '1) begin
                        upd_count_d = upd_count_q + (IDX_W + 1)'(1);
                    end
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (upd_done) begin
                    state_d = S_SCAN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = S_SCAN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sticky flags: a set event in the same cycle beats clear_err.
        if (step_start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (timeout_set) begin
            timeout_err_d = 1'b1;
        end else if (clear_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        upd_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        step_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            pre_q         <= '0;
            post_q        <= 1'b0;
            upd_idx_q     <= '0;
            upd_pre_q     <= 1'b0;
            upd_post_q    <= 1'b0;
            upd_count_q   <= '0;
            wait_cnt_q    <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            upd_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            step_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            pre_q         <= pre_d;
            post_q        <= post_d;
            upd_idx_q     <= upd_idx_d;
            upd_pre_q     <= upd_pre_d;
            upd_post_q    <= upd_post_d;
            upd_count_q   <= upd_count_d;
            wait_cnt_q    <= wait_cnt_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            upd_valid_q   <= upd_valid_d;
            busy_q        <= busy_d;
            step_done_q   <= step_done_d;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_idx     = upd_idx_q;
    assign upd_pre     = upd_pre_q;
    assign upd_post    = upd_post_q;
    assign busy        = busy_q;
    assign step_done   = step_done_q;
    assign upd_count   = upd_count_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;

endmodule
